gcd_engine: RTL and testbench

Iterative greatest-common-divisor responder for the three-cycle load/x/y serial protocol driven by the GCD calculator front end. It captures a `load` strobe, then operand x and operand y on the two following cycles, and runs Euclid's algorithm by repeated subtraction. It then presents `gcd_result` with a level `done` that holds until the initiator clears or reloads it. It is the execution core underneath the calculator FSM, one instance per calculator.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_if.sv | 45 ++++
 rtl/gcd_step.sv | 35 +++
 rtl/gcd_engine.sv | 111 +++++++++++
 tb/tb_gcd_engine.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD engine and the calculator
// front end that drives it.
//   gcd_state_t        - engine FSM state encoding (also exported for debug)
//   GCD_WIDTH_DEFAULT  - default operand/result width in bits
package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_X   = 3'd1,
        GET_Y   = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } gcd_state_t;

endpackage

// File: rtl/gcd_if.sv
// gcd_if: initiator <-> engine signal bundle for the load/x/y serial protocol.
//   clear      : synchronous abort/re-arm pulse (initiator -> engine)
//   load       : start strobe; x then y follow on data (initiator -> engine)
//   data       : operand bus, sampled only in the two cycles after load
//   gcd_result : registered result, valid while done=1 (engine -> initiator)
//   done       : level, high while a result is held
//   busy       : high from the cycle after load until done rises
//   state      : engine FSM state, for observation/debug only
//
// Handshake: a transaction is load followed by exactly two data beats; there
// is no back-pressure. done is a level that holds until the initiator issues
// clear or a new load, so the initiator may sample it on any cycle.
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] gcd_result;
    logic             done;
    logic             busy;
    gcd_state_t       state;

    modport master (
        output clear,
        output load,
        output data,
        input  gcd_result,
        input  done,
        input  busy,
        input  state
    );

    modport slave (
        input  clear,
        input  load,
        input  data,
        output gcd_result,
        output done,
        output busy,
        output state
    );
endinterface

// File: rtl/gcd_step.sv
// gcd_step: one iteration of subtractive Euclid, purely combinational.
//   x, y      : current operands
//   next_x/y  : operands after one subtraction (unchanged when finished)
//   finished  : x==0, y==0 or x==y; no further subtraction needed
//   result    : the gcd when finished (y if x==0, else x)
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] next_x,
    output logic [WIDTH-1:0] next_y,
    output logic             finished,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        next_x   = x;
        next_y   = y;
        finished = (x == '0) || (y == '0) || (x == y);
        // x==0 covers gcd(0,n)=n and gcd(0,0)=0; otherwise x is the answer.
        result   = (x == '0) ? y : x;
        if (!finished) begin
            // Larger value is always the minuend, so no underflow.
            if (x > y) begin
                next_x = x - y;
            end else begin
                next_y = y - x;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: iterative GCD responder. Captures load, then x, then y on the
// following two cycles, subtracts one step per cycle, then holds the result
// with done=1 until clear or a new load.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : gcd_if slave (clear, load, data in; gcd_result, done, busy,
//             state out)
// Priority in every state: reset_n > clear > load > normal transition.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    gcd_if.slave bus
);

    gcd_state_t       cur_state, nxt_state;
    logic [WIDTH-1:0] x, y, x_nxt, y_nxt;
    logic [WIDTH-1:0] result, result_nxt;
    logic             done_r, done_nxt;
    logic             busy_r, busy_nxt;

    logic [WIDTH-1:0] step_next_x, step_next_y, step_result;
    logic             step_finished;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .x        (x),
        .y        (y),
        .next_x   (step_next_x),
        .next_y   (step_next_y),
        .finished (step_finished),
        .result   (step_result)
    );

    // State and all output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            x         <= '0;
            y         <= '0;
            result    <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            x         <= x_nxt;
            y         <= y_nxt;
            result    <= result_nxt;
            done_r    <= done_nxt;
            busy_r    <= busy_nxt;
        end
    end

    // Next state and operand datapath.
    always_comb begin
        nxt_state = cur_state;
        x_nxt     = x;
        y_nxt     = y;
        if (bus.clear) begin
            nxt_state = IDLE;
            x_nxt     = '0;
            y_nxt     = '0;
        end else if (bus.load) begin
            // Restart from any state; old operands are simply overwritten.
            nxt_state = GET_X;
        end else begin
            case (cur_state)
                IDLE: ;
                GET_X: begin
                    x_nxt     = bus.data;
                    nxt_state = GET_Y;
                end
                GET_Y: begin
                    y_nxt     = bus.data;
                    nxt_state = COMPUTE;
                end
                COMPUTE: begin
                    if (step_finished) begin
                        nxt_state = DONE;
                    end else begin
                        x_nxt = step_next_x;
                        y_nxt = step_next_y;
                    end
                end
                DONE: ;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Registered-output next values. done/busy follow the state being
    // entered so they are aligned with it after the edge.
    always_comb begin
        done_nxt   = (nxt_state == DONE);
        busy_nxt   = (nxt_state == GET_Y) || (nxt_state == COMPUTE);
        result_nxt = result;
        if (bus.clear) begin
            result_nxt = '0;
        end else if (!bus.load && (cur_state == COMPUTE) && step_finished) begin
            result_nxt = step_result;
        end
    end

    assign bus.gcd_result = result;
    assign bus.done       = done_r;
    assign bus.busy       = busy_r;
    assign bus.state      = cur_state;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: self-checking bench for gcd_engine. Directed scenarios plus
// random operand pairs, checked against a reference built from modulo-based
// Euclid (result) and quotient sums (subtraction count / latency).
module tb_gcd_engine;
    import gcd_pkg::*;

    localparam int W      = 8;
    localparam int BUDGET = 400;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    gcd_if #(.WIDTH(W)) bus ();

    gcd_engine #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           n_cmp;
    int           n_fail;
    int           busy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive Euclid does the quotients of modulo Euclid one unit at a
    // time and stops one subtraction early (when the operands are equal).
    function automatic int ref_steps(input int a, input int b);
        int s;
        int t;
        if (a == 0 || b == 0) return 0;
        s = 0;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s - 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves time just after E2.
    task automatic start_load(input int xv, input int yv);
        // A new load discards whatever was in flight.
        exp_q.delete();
        lat_q.delete();
        exp_q.push_back(W'(ref_gcd(xv, yv)));
        lat_q.push_back(3 + ref_steps(xv, yv));
        bus.load = 1'b1;
        bus.data = W'($urandom);
        tick();                                  // E0
        chk("e0_done", bus.done, 0);
        chk("e0_busy", bus.busy, 0);
        bus.load = 1'b0;
        bus.data = W'(xv);
        tick();                                  // E1
        busy_cnt = 0;
        if (bus.busy) busy_cnt++;
        bus.data = W'(yv);
        tick();                                  // E2
        if (bus.busy) busy_cnt++;
        bus.data = W'($urandom);
    endtask

    // Called just after E2; waits for done and checks result and timing.
    task automatic wait_done(input string tag);
        int           edges;
        int           lat;
        logic [W-1:0] exp_r;
        logic [W-1:0] held;
        edges = 2;
        while (!bus.done && edges < BUDGET) begin
            tick();
            edges++;
            bus.data = W'($urandom);
            if (bus.busy) busy_cnt++;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        exp_r = exp_q.pop_front();
        lat   = lat_q.pop_front();
        chk({tag, "_latency"}, edges, lat);
        chk({tag, "_result"}, bus.gcd_result, exp_r);
        chk({tag, "_busy_cycles"}, busy_cnt, lat - 1);
        chk({tag, "_busy_low"}, bus.busy, 0);
        held = bus.gcd_result;
        repeat (3) begin
            bus.data = W'($urandom);
            tick();
        end
        chk({tag, "_hold_done"}, bus.done, 1);
        chk({tag, "_hold_result"}, bus.gcd_result, held);
    endtask

    task automatic run_op(input string tag, input int xv, input int yv);
        start_load(xv, yv);
        wait_done(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_seen;
        int rx;
        int ry;
        n_cmp     = 0;
        n_fail    = 0;
        busy_cnt  = 0;
        reset_n   = 1'b1;
        bus.clear = 1'b0;
        bus.load  = 1'b0;
        bus.data  = '0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.gcd_result, 0);
        chk("rst_state", bus.state, IDLE);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        tick();
        chk("idle_state", bus.state, IDLE);

        // Basic and zero/equal cases
        run_op("g12_18", 12, 18);
        run_op("g7_7", 7, 7);
        run_op("g0_9", 0, 9);
        run_op("g9_0", 9, 0);
        run_op("g0_0", 0, 0);

        // Worst case both orders
        run_op("g255_1", 255, 1);
        run_op("g1_255", 1, 255);

        // clear at E10 during (200,3)
        start_load(200, 3);
        repeat (7) tick();                       // now just after E9
        bus.clear = 1'b1;
        tick();                                  // E10
        bus.clear = 1'b0;
        exp_q.delete();
        lat_q.delete();
        chk("clr_done", bus.done, 0);
        chk("clr_busy", bus.busy, 0);
        chk("clr_result", bus.gcd_result, 0);
        chk("clr_state", bus.state, IDLE);
        run_op("g48_36", 48, 36);

        // Asynchronous reset mid-COMPUTE
        start_load(255, 1);
        repeat (20) tick();
        reset_n = 1'b0;
        #2;
        chk("arst_done", bus.done, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_result", bus.gcd_result, 0);
        chk("arst_state", bus.state, IDLE);
        exp_q.delete();
        lat_q.delete();
        @(posedge clock);
        #3 reset_n = 1'b1;
        tick();
        run_op("g21_14", 21, 14);

        // Restart during COMPUTE: aborted op must never raise done
        start_load(100, 1);
        done_seen = 0;
        repeat (5) begin
            tick();
            if (bus.done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_op("g9_6", 9, 6);

        // load while in DONE: done drops at E0 (checked in start_load)
        run_op("g17_5", 17, 5);

        // Random pairs
        for (int i = 0; i < 10; i++) begin
            rx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            ry = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op("rand", rx, ry);
        end

        // ---------------- final report ----------------
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
